// File: rtl/sram_port_arbiter_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM port arbiter.
// FSM encoding, requester port ids and the access/turn counter width.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_TURN   = 2'd3
    } arb_state_e;

    localparam logic PORT_IF   = 1'b0;
    localparam logic PORT_DATA = 1'b1;

    // Both counters must cover the largest legal ACCESS_CYCLES value.
    localparam int CNT_MAX = 15;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

endpackage

// File: rtl/sram_port_arbiter_pick.sv
// sram_arb_pick: combinational winner select for the two SRAM requesters.
// SRAM_ARB_RR_EN selects round-robin on the last-grant pointer; otherwise port 1 has fixed priority.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
`ifdef SRAM_ARB_RR_EN
    input  logic       last_grant,
`endif
    output logic [1:0] grant
);

`ifdef SRAM_ARB_RR_EN
    // Round-robin: on conflict the port that did not win last time is served.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            if (last_grant == PORT_DATA) begin
                grant = 2'b01;
            end else begin
                grant = 2'b10;
            end
        end else begin
            grant = req;
        end
    end
`else
    // Fixed priority: the data port always beats instruction fetch.
    always_comb begin
        grant = 2'b00;
        if (req[PORT_DATA]) begin
            grant = 2'b10;
        end else if (req[PORT_IF]) begin
            grant = 2'b01;
        end else begin
            grant = 2'b00;
        end
    end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one ram_wrapper io_sram_* port between ifetch (m0) and data (m1) masters.
// Optional macro SRAM_ARB_RR_EN switches from fixed data-first priority to round-robin arbitration.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 32,
    parameter int ACCESS_CYCLES = 2,
    parameter int WR_TURN       = 1
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wmask,
    output logic                m0_done,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wmask,
    output logic                m1_done,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                sram_en,
    output logic                sram_re,
    output logic                sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_din,
    output logic [DATA_W/8-1:0] sram_wmask,
    input  logic [DATA_W-1:0]   sram_dout
);

    localparam int MASK_W = DATA_W / 8;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(WR_TURN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam bit               HAS_TURN  = (WR_TURN > 0);

    arb_state_e         state_r, state_nx_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nx_s;
    logic [CNT_W-1:0]   turn_r, turn_nx_s;
    logic               we_r, we_nx_s;
    logic               win_r, win_nx_s;
    logic [1:0]         grant_s;

    logic               sel_we_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_wdata_s;
    logic [MASK_W-1:0]  sel_wmask_s;

    logic               en_nx_s, re_nx_s, wr_nx_s;
    logic [ADDR_W-1:0]  addr_nx_s;
    logic [DATA_W-1:0]  din_nx_s;
    logic [MASK_W-1:0]  wmask_nx_s;
    logic               done0_nx_s, done1_nx_s;
    logic [DATA_W-1:0]  rdata0_nx_s, rdata1_nx_s;

`ifdef SRAM_ARB_RR_EN
    logic               last_r;

    sram_arb_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (last_r),
        .grant      (grant_s)
    );

    // Last-grant pointer, advanced on every grant taken in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_r <= PORT_DATA;
        end else if ((state_r == ST_IDLE) && (grant_s != 2'b00)) begin
            last_r <= grant_s[PORT_DATA];
        end else begin
            last_r <= last_r;
        end
    end
`else
    sram_arb_pick u_pick (
        .req   ({m1_req, m0_req}),
        .grant (grant_s)
    );
`endif

    // Route the winning requester's attributes toward the latch point.
    always_comb begin
        if (grant_s[PORT_DATA]) begin
            sel_we_s    = m1_we;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
            sel_wmask_s = m1_wmask;
        end else begin
            sel_we_s    = m0_we;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
            sel_wmask_s = m0_wmask;
        end
    end

    // Next-state and next-output logic; every output is taken from a register.
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        turn_nx_s   = turn_r;
        we_nx_s     = we_r;
        win_nx_s    = win_r;
        en_nx_s     = sram_en;
        re_nx_s     = sram_re;
        wr_nx_s     = sram_we;
        addr_nx_s   = sram_addr;
        din_nx_s    = sram_din;
        wmask_nx_s  = sram_wmask;
        done0_nx_s  = 1'b0;
        done1_nx_s  = 1'b0;
        rdata0_nx_s = m0_rdata;
        rdata1_nx_s = m1_rdata;
        case (state_r)
            ST_IDLE: begin
                if (grant_s != 2'b00) begin
                    state_nx_s = ST_ACCESS;
                    cnt_nx_s   = CNT_LOAD;
                    we_nx_s    = sel_we_s;
                    win_nx_s   = grant_s[PORT_DATA];
                    en_nx_s    = 1'b1;
                    re_nx_s    = ~sel_we_s;
                    wr_nx_s    = sel_we_s;
                    addr_nx_s  = sel_addr_s;
                    din_nx_s   = sel_wdata_s;
                    wmask_nx_s = sel_we_s ? sel_wmask_s : {MASK_W{1'b0}};
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nx_s = ST_DONE;
                    en_nx_s    = 1'b0;
                    re_nx_s    = 1'b0;
                    wr_nx_s    = 1'b0;
                    wmask_nx_s = {MASK_W{1'b0}};
                    done0_nx_s = (win_r == PORT_IF);
                    done1_nx_s = (win_r == PORT_DATA);
                    if (!we_r && (win_r == PORT_DATA)) begin
                        rdata1_nx_s = sram_dout;
                    end else if (!we_r) begin
                        rdata0_nx_s = sram_dout;
                    end else begin
                        rdata0_nx_s = m0_rdata;
                    end
                end else begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end
            end
            ST_DONE: begin
                if (we_r && HAS_TURN) begin
                    state_nx_s = ST_TURN;
                    turn_nx_s  = TURN_LOAD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_TURN: begin
                if (turn_r == CNT_ZERO) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    turn_nx_s = turn_r - CNT_ONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, latched request and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            turn_r     <= CNT_ZERO;
            we_r       <= 1'b0;
            win_r      <= PORT_IF;
            sram_en    <= 1'b0;
            sram_re    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= {ADDR_W{1'b0}};
            sram_din   <= {DATA_W{1'b0}};
            sram_wmask <= {MASK_W{1'b0}};
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
            m0_rdata   <= {DATA_W{1'b0}};
            m1_rdata   <= {DATA_W{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            turn_r     <= turn_nx_s;
            we_r       <= we_nx_s;
            win_r      <= win_nx_s;
            sram_en    <= en_nx_s;
            sram_re    <= re_nx_s;
            sram_we    <= wr_nx_s;
            sram_addr  <= addr_nx_s;
            sram_din   <= din_nx_s;
            sram_wmask <= wmask_nx_s;
            m0_done    <= done0_nx_s;
            m1_done    <= done1_nx_s;
            m0_rdata   <= rdata0_nx_s;
            m1_rdata   <= rdata1_nx_s;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed bench for sram_port_arbiter with a small synchronous-read SRAM model.
// Covers reset/abort, single read, write+turn+read, byte write, and conflict arbitration (fixed or SRAM_ARB_RR_EN).
module tb_sram_port_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m0_done;
    logic [19:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic [3:0]  m0_wmask;
    logic        m1_req, m1_we, m1_done;
    logic [19:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic [3:0]  m1_wmask;
    logic        sram_en, sram_re, sram_we;
    logic [19:0] sram_addr;
    logic [31:0] sram_din, sram_dout;
    logic [3:0]  sram_wmask;

    int n_pass  = 0;
    int n_total = 0;
    int rd_mask_bad = 0;
    int t0, t1, ndone, nen, cnt0, cnt1;

    logic [31:0] mem [0:1023];

    sram_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .m0_req     (m0_req),
        .m0_we      (m0_we),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_wmask   (m0_wmask),
        .m0_done    (m0_done),
        .m0_rdata   (m0_rdata),
        .m1_req     (m1_req),
        .m1_we      (m1_we),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_wmask   (m1_wmask),
        .m1_done    (m1_done),
        .m1_rdata   (m1_rdata),
        .sram_en    (sram_en),
        .sram_re    (sram_re),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_wmask (sram_wmask),
        .sram_dout  (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: registered read data, byte-masked writes.
    always @(posedge clk) begin
        if (sram_en && sram_re) sram_dout <= mem[sram_addr[9:0]];
        if (sram_en && sram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_wmask[b]) mem[sram_addr[9:0]][8*b +: 8] <= sram_din[8*b +: 8];
            end
        end
    end

    // A read must never carry byte enables.
    always @(negedge clk) begin
        if (!reset && sram_en && sram_re && (sram_wmask != 4'h0)) rd_mask_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 20'h0; m0_wdata = 32'h0; m0_wmask = 4'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 20'h0; m1_wdata = 32'h0; m1_wmask = 4'h0;
        sram_dout = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        tick();
        tick();
        chk("rst_en", {29'd0, sram_en, sram_re, sram_we}, 32'd0);
        chk("rst_done", {30'd0, m0_done, m1_done}, 32'd0);
        chk("rst_addr", {12'd0, sram_addr}, 32'd0);
        chk("rst_rdata1", m1_rdata, 32'd0);
        reset = 1'b0;
        tick();

        // Single read by m0 at 0x00004.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 20'h00004;
        tick();
        chk("rd_c1_ctl", {29'd0, sram_en, sram_re, sram_we}, 32'd6);
        chk("rd_c1_addr", {12'd0, sram_addr}, 32'h4);
        tick();
        chk("rd_c2_en", {31'd0, sram_en}, 32'd1);
        chk("rd_c2_done", {31'd0, m0_done}, 32'd0);
        tick();
        chk("rd_c3_done", {30'd0, m0_done, sram_en}, 32'd2);
        chk("rd_c3_rdata", m0_rdata, 32'hDEADBEEF);
        m0_req = 1'b0;
        tick();
        chk("rd_c4_done", {31'd0, m0_done}, 32'd0);
        chk("rd_c4_hold", m0_rdata, 32'hDEADBEEF);

        // Reset in the middle of an m1 read at 0x00010 aborts it without a clock edge.
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 20'h00010;
        tick();
        chk("ab_c1_en", {31'd0, sram_en}, 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("ab_ctl", {28'd0, sram_en, sram_re, sram_we, m1_done}, 32'd0);
        chk("ab_rdata0", m0_rdata, 32'd0);
        m1_req = 1'b0;
        tick();
        reset = 1'b0;
        ndone = 0; nen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (m0_done || m1_done) ndone++;
            if (sram_en) nen++;
        end
        chk("ab_no_done", ndone, 32'd0);
        chk("ab_no_en", nen, 32'd0);

        // m1 write 0x12345678 to 0x00100, then read it back across the write turnaround.
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 20'h00100; m1_wdata = 32'h12345678; m1_wmask = 4'hF;
        tick();
        chk("wr_c1_ctl", {29'd0, sram_en, sram_re, sram_we}, 32'd5);
        chk("wr_c1_mask", {28'd0, sram_wmask}, 32'hF);
        chk("wr_c1_din", sram_din, 32'h12345678);
        tick();
        tick();
        chk("wr_c3_done", {31'd0, m1_done}, 32'd1);
        m1_we = 1'b0;
        tick();
        chk("wr_turn_en", {31'd0, sram_en}, 32'd0);
        tick();
        chk("wr_idle_en", {31'd0, sram_en}, 32'd0);
        tick();
        chk("rb_c1_ctl", {29'd0, sram_en, sram_re, sram_we}, 32'd6);
        tick();
        tick();
        chk("rb_done", {31'd0, m1_done}, 32'd1);
        chk("rb_rdata", m1_rdata, 32'h12345678);
        m1_req = 1'b0;
        tick();

        // Byte write of lane 1, then read back the merged word.
        m1_req = 1'b1; m1_we = 1'b1; m1_wdata = 32'h0000AB00; m1_wmask = 4'h2;
        tick();
        chk("bw_mask", {28'd0, sram_wmask}, 32'h2);
        tick();
        tick();
        chk("bw_done", {31'd0, m1_done}, 32'd1);
        m1_we = 1'b0;
        t1 = -1;
        for (int i = 1; i <= 12 && t1 < 0; i++) begin
            tick();
            if (m1_done) t1 = i;
        end
        chk("bw_rb_lat", t1, 32'd5);
        chk("bw_rb_rdata", m1_rdata, 32'h1234AB78);
        m1_req = 1'b0;
        tick();

`ifdef SRAM_ARB_RR_EN
        // Make port 0 the last winner so the conflict run starts with port 1.
        m0_req = 1'b1;
        t0 = -1;
        for (int i = 1; i <= 10 && t0 < 0; i++) begin
            tick();
            if (m0_done) t0 = i;
        end
        chk("rr_pre_lat", t0, 32'd3);
        m0_req = 1'b0;
        tick();
        m0_req = 1'b1; m0_addr = 20'h00004;
        m1_req = 1'b1; m1_addr = 20'h00100;
        ndone = 0; cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 60 && ndone < 8; i++) begin
            tick();
            if (m0_done || m1_done) begin
                chk("rr_order", {30'd0, m1_done, m0_done}, (ndone % 2 == 0) ? 32'd2 : 32'd1);
                if (m0_done) cnt0++;
                if (m1_done) cnt1++;
                ndone++;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("rr_cnt0", cnt0, 32'd4);
        chk("rr_cnt1", cnt1, 32'd4);
`else
        // Simultaneous requests: data port first, ifetch ACCESS_CYCLES+2 cycles later.
        m0_req = 1'b1; m0_addr = 20'h00004;
        m1_req = 1'b1; m1_addr = 20'h00100;
        t0 = -1; t1 = -1;
        for (int i = 1; i <= 20 && (t0 < 0 || t1 < 0); i++) begin
            tick();
            if (m1_done && t1 < 0) begin
                t1 = i;
                m1_req = 1'b0;
                chk("cf_rdata1", m1_rdata, 32'h1234AB78);
            end
            if (m0_done && t0 < 0) begin
                t0 = i;
                m0_req = 1'b0;
                chk("cf_rdata0", m0_rdata, 32'hDEADBEEF);
            end
        end
        chk("cf_t1", t1, 32'd3);
        chk("cf_t0", t0, 32'd7);
`endif

        tick();
        tick();
        chk("rd_wmask_zero", rd_mask_bad, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
